// File: rtl/vram_slot_arbiter.sv
// Shares the SDRAM controller port between the VDP slot, an aux requester and refresh.
// Optional build macro ARB_STATS_EN adds saturating statistics counters and their ports.
module vram_slot_arbiter #(
    parameter int ADDR_W      = 17,
    parameter int REFRESH_MAX = 8,
    parameter int MIN_WAIT    = 2
) (
    input  logic              clk_w,
    input  logic              reset_n_w,
    input  logic              vdp_dlclk,
    input  logic              vdp_dhclk,
    input  logic              vdp_we_n,
    input  logic [ADDR_W-1:0] vdp_addr,
    input  logic [7:0]        vdp_wdata,
    output logic [15:0]       vdp_rdata,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [7:0]        aux_wdata,
    output logic              aux_ack,
    output logic [7:0]        aux_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_refresh,
    output logic [20:0]       mem_addr,
    output logic [15:0]       mem_din,
    output logic [1:0]        mem_wdm,
    input  logic [15:0]       mem_dout,
    input  logic              mem_busy,
    output logic              slot_overrun
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       stat_overruns,
    output logic [15:0]       stat_aux_grants,
    output logic [15:0]       stat_forced_refresh
`endif
);

    localparam int RC_W = (REFRESH_MAX < 1) ? 1 : $clog2(REFRESH_MAX + 1);
    localparam int WC_W = (MIN_WAIT < 1) ? 1 : $clog2(MIN_WAIT + 1);
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(REFRESH_MAX);
    localparam logic [WC_W-1:0] WC_MIN = WC_W'(MIN_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        VDP_WAIT,
        AUX_WAIT,
        REF_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic              slotDone_q, slotDone_d;
    logic [RC_W-1:0]   refCnt_q, refCnt_d;
    logic              refDone_q, refDone_d;
    logic              idlePhase_q, vdpPhase_q;
    logic [WC_W-1:0]   waitCnt_q, waitCnt_d;
    logic              isRead_q, isRead_d;
    logic              lane_q, lane_d;
    logic              memRead_q, memRead_d;
    logic              memWrite_q, memWrite_d;
    logic              memRefresh_q, memRefresh_d;
    logic [20:0]       memAddr_q, memAddr_d;
    logic [15:0]       memDin_q, memDin_d;
    logic [1:0]        memWdm_q, memWdm_d;
    logic [15:0]       vdpRdata_q, vdpRdata_d;
    logic              auxAck_q, auxAck_d;
    logic [7:0]        auxRdata_q, auxRdata_d;
    logic              overrun_q, overrun_d;

    logic vdpPhase, idlePhase, waitDone;
    logic issueVdp, issueAux, issueRef, forcedRef;

    assign vdpPhase  = vdp_dlclk & vdp_dhclk;
    assign idlePhase = ~vdp_dlclk & ~vdp_dhclk;

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            state_q      <= IDLE;
            slotDone_q   <= 1'b0;
            refCnt_q     <= '0;
            refDone_q    <= 1'b0;
            idlePhase_q  <= 1'b0;
            vdpPhase_q   <= 1'b0;
            waitCnt_q    <= '0;
            isRead_q     <= 1'b0;
            lane_q       <= 1'b0;
            memRead_q    <= 1'b0;
            memWrite_q   <= 1'b0;
            memRefresh_q <= 1'b0;
            memAddr_q    <= '0;
            memDin_q     <= '0;
            memWdm_q     <= '0;
            vdpRdata_q   <= '0;
            auxAck_q     <= 1'b0;
            auxRdata_q   <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slotDone_q   <= slotDone_d;
            refCnt_q     <= refCnt_d;
            refDone_q    <= refDone_d;
            idlePhase_q  <= idlePhase;
            vdpPhase_q   <= vdpPhase;
            waitCnt_q    <= waitCnt_d;
            isRead_q     <= isRead_d;
            lane_q       <= lane_d;
            memRead_q    <= memRead_d;
            memWrite_q   <= memWrite_d;
            memRefresh_q <= memRefresh_d;
            memAddr_q    <= memAddr_d;
            memDin_q     <= memDin_d;
            memWdm_q     <= memWdm_d;
            vdpRdata_q   <= vdpRdata_d;
            auxAck_q     <= auxAck_d;
            auxRdata_q   <= auxRdata_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        slotDone_d   = slotDone_q;
        refCnt_d     = refCnt_q;
        refDone_d    = refDone_q;
        isRead_d     = isRead_q;
        lane_d       = lane_q;
        memRead_d    = 1'b0;
        memWrite_d   = 1'b0;
        memRefresh_d = 1'b0;
        memAddr_d    = memAddr_q;
        memDin_d     = memDin_q;
        memWdm_d     = memWdm_q;
        vdpRdata_d   = vdpRdata_q;
        auxAck_d     = 1'b0;
        auxRdata_d   = auxRdata_q;
        issueVdp     = 1'b0;
        issueAux     = 1'b0;
        issueRef     = 1'b0;
        forcedRef    = 1'b0;
        waitCnt_d    = (waitCnt_q >= WC_MIN) ? waitCnt_q : waitCnt_q + 1'b1;
        // waitCnt counts cycles in a WAIT state after the strobe cycle itself
        waitDone     = !mem_busy && (waitCnt_q >= WC_MIN);
        overrun_d    = vdpPhase_q & ~vdpPhase & ~slotDone_q;

        if (!vdpPhase) begin
            slotDone_d = 1'b0;
        end

        if (idlePhase_q && !idlePhase) begin
            if (!refDone_q && (refCnt_q < RC_MAX)) begin
                refCnt_d = refCnt_q + 1'b1;
            end
            refDone_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!mem_busy) begin
                    if (vdpPhase && !slotDone_q) begin
                        issueVdp = 1'b1;
                    end else if (idlePhase && (refCnt_q >= RC_MAX)) begin
                        issueRef  = 1'b1;
                        forcedRef = 1'b1;
                    end else if (idlePhase && aux_req) begin
                        issueAux = 1'b1;
                    end else if (idlePhase && !refDone_q) begin
                        issueRef = 1'b1;
                    end
                end
            end
            VDP_WAIT: begin
                if (waitDone) begin
                    state_d = IDLE;
                    if (isRead_q) begin
                        vdpRdata_d = mem_dout;
                    end
                end
            end
            AUX_WAIT: begin
                if (waitDone) begin
                    state_d  = IDLE;
                    auxAck_d = 1'b1;
                    if (isRead_q) begin
                        auxRdata_d = lane_q ? mem_dout[15:8] : mem_dout[7:0];
                    end
                end
            end
            REF_WAIT: begin
                if (waitDone) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issueVdp) begin
            state_d    = VDP_WAIT;
            slotDone_d = 1'b1;
            waitCnt_d  = '0;
            isRead_d   = vdp_we_n;
            lane_d     = vdp_addr[ADDR_W-1];
            memRead_d  = vdp_we_n;
            memWrite_d = ~vdp_we_n;
            memAddr_d  = {5'b0, vdp_addr[15:0]};
            memDin_d   = {vdp_wdata, vdp_wdata};
            memWdm_d   = {~vdp_addr[ADDR_W-1], vdp_addr[ADDR_W-1]};
        end
        if (issueAux) begin
            state_d    = AUX_WAIT;
            waitCnt_d  = '0;
            isRead_d   = ~aux_we;
            lane_d     = aux_addr[ADDR_W-1];
            memRead_d  = ~aux_we;
            memWrite_d = aux_we;
            memAddr_d  = {5'b0, aux_addr[15:0]};
            memDin_d   = {aux_wdata, aux_wdata};
            memWdm_d   = {~aux_addr[ADDR_W-1], aux_addr[ADDR_W-1]};
        end
        // Refresh leaves the address/data registers untouched; they carry no meaning for it
        if (issueRef) begin
            state_d      = REF_WAIT;
            waitCnt_d    = '0;
            memRefresh_d = 1'b1;
            refCnt_d     = '0;
            refDone_d    = 1'b1;
        end
    end

    assign vdp_rdata    = vdpRdata_q;
    assign aux_ack      = auxAck_q;
    assign aux_rdata    = auxRdata_q;
    assign mem_read     = memRead_q;
    assign mem_write    = memWrite_q;
    assign mem_refresh  = memRefresh_q;
    assign mem_addr     = memAddr_q;
    assign mem_din      = memDin_q;
    assign mem_wdm      = memWdm_q;
    assign slot_overrun = overrun_q;

`ifdef ARB_STATS_EN
    logic [15:0] statOverruns_q, statAuxGrants_q, statForced_q;

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            statOverruns_q  <= '0;
            statAuxGrants_q <= '0;
            statForced_q    <= '0;
        end else begin
            if (overrun_d && (statOverruns_q != 16'hFFFF)) begin
                statOverruns_q <= statOverruns_q + 16'd1;
            end
            if (auxAck_d && (statAuxGrants_q != 16'hFFFF)) begin
                statAuxGrants_q <= statAuxGrants_q + 16'd1;
            end
            if (forcedRef && (statForced_q != 16'hFFFF)) begin
                statForced_q <= statForced_q + 16'd1;
            end
        end
    end

    assign stat_overruns       = statOverruns_q;
    assign stat_aux_grants     = statAuxGrants_q;
    assign stat_forced_refresh = statForced_q;
`endif

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Directed bench for vram_slot_arbiter: VDP read/write, aux read, refresh starvation, overrun, async reset.
module tb_vram_slot_arbiter;

    logic        clk_w = 1'b0;
    logic        reset_n_w;
    logic        vdp_dlclk, vdp_dhclk, vdp_we_n;
    logic [16:0] vdp_addr;
    logic [7:0]  vdp_wdata;
    logic [15:0] vdp_rdata;
    logic        aux_req, aux_we;
    logic [16:0] aux_addr;
    logic [7:0]  aux_wdata;
    logic        aux_ack;
    logic [7:0]  aux_rdata;
    logic        mem_read, mem_write, mem_refresh;
    logic [20:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_wdm;
    logic [15:0] mem_dout;
    logic        mem_busy;
    logic        slot_overrun;
`ifdef ARB_STATS_EN
    logic [15:0] stat_overruns, stat_aux_grants, stat_forced_refresh;
`endif

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int rdCnt  = 0;
    int wrCnt  = 0;
    int refCnt = 0;
    int ackCnt = 0;
    int ovrCnt = 0;

    always #5 clk_w = ~clk_w;

    vram_slot_arbiter #(.ADDR_W(17), .REFRESH_MAX(8), .MIN_WAIT(2)) dut (
        .clk_w        (clk_w),
        .reset_n_w    (reset_n_w),
        .vdp_dlclk    (vdp_dlclk),
        .vdp_dhclk    (vdp_dhclk),
        .vdp_we_n     (vdp_we_n),
        .vdp_addr     (vdp_addr),
        .vdp_wdata    (vdp_wdata),
        .vdp_rdata    (vdp_rdata),
        .aux_req      (aux_req),
        .aux_we       (aux_we),
        .aux_addr     (aux_addr),
        .aux_wdata    (aux_wdata),
        .aux_ack      (aux_ack),
        .aux_rdata    (aux_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_refresh  (mem_refresh),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_wdm      (mem_wdm),
        .mem_dout     (mem_dout),
        .mem_busy     (mem_busy),
        .slot_overrun (slot_overrun)
`ifdef ARB_STATS_EN
        ,
        .stat_overruns       (stat_overruns),
        .stat_aux_grants     (stat_aux_grants),
        .stat_forced_refresh (stat_forced_refresh)
`endif
    );

    // Pulse counters sampled mid-cycle; each high sample is one cycle of strobe
    always @(negedge clk_w) begin
        if (mem_read)     rdCnt++;
        if (mem_write)    wrCnt++;
        if (mem_refresh)  refCnt++;
        if (aux_ack)      ackCnt++;
        if (slot_overrun) ovrCnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) begin
            passes++;
        end else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic dl, input logic dh, input int cycles);
        vdp_dlclk = dl;
        vdp_dhclk = dh;
        repeat (cycles) @(posedge clk_w);
        #1;
    endtask

    task automatic waitAck(input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk_w);
            #1;
            if (aux_ack) seen = 1'b1;
        end
    endtask

    initial begin
        int   rd0, wr0, ref0, ack0, ovr0;
        int   phaseRef [20];
        int   phaseAck [20];
        int   earlyRef, ackedPhases, totalRef;
        logic seen;

        reset_n_w = 1'b0;
        vdp_dlclk = 1'b1;
        vdp_dhclk = 1'b0;
        vdp_we_n  = 1'b1;
        vdp_addr  = '0;
        vdp_wdata = '0;
        aux_req   = 1'b0;
        aux_we    = 1'b0;
        aux_addr  = '0;
        aux_wdata = '0;
        mem_dout  = '0;
        mem_busy  = 1'b0;

        repeat (3) @(posedge clk_w);
        #1;
        checkOutput("rstMemRead", 32'(mem_read), 32'd0);
        checkOutput("rstMemWrite", 32'(mem_write), 32'd0);
        checkOutput("rstMemRefresh", 32'(mem_refresh), 32'd0);
        checkOutput("rstAuxAck", 32'(aux_ack), 32'd0);
        checkOutput("rstMemAddr", 32'(mem_addr), 32'd0);
        checkOutput("rstVdpRdata", 32'(vdp_rdata), 32'd0);
        checkOutput("rstOverrun", 32'(slot_overrun), 32'd0);
        reset_n_w = 1'b1;
        applyStimulus(1'b1, 1'b0, 2);

        // VDP read of word 0x1234
        vdp_we_n = 1'b1;
        vdp_addr = 17'h0_1234;
        mem_dout = 16'hA55A;
        rd0 = rdCnt; wr0 = wrCnt; ovr0 = ovrCnt;
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 2);
        checkOutput("vdpRdCount", 32'(rdCnt - rd0), 32'd1);
        checkOutput("vdpRdNoWrite", 32'(wrCnt - wr0), 32'd0);
        checkOutput("vdpRdAddr", 32'(mem_addr), 32'h0000_1234);
        checkOutput("vdpRdData", 32'(vdp_rdata), 32'h0000_A55A);
        checkOutput("vdpRdNoOverrun", 32'(ovrCnt - ovr0), 32'd0);

        // VDP write to the high byte lane
        vdp_we_n  = 1'b0;
        vdp_addr  = 17'h1_0010;
        vdp_wdata = 8'h3C;
        mem_dout  = 16'h0000;
        wr0 = wrCnt; rd0 = rdCnt;
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 2);
        checkOutput("vdpWrCount", 32'(wrCnt - wr0), 32'd1);
        checkOutput("vdpWrNoRead", 32'(rdCnt - rd0), 32'd0);
        checkOutput("vdpWrDin", 32'(mem_din), 32'h0000_3C3C);
        checkOutput("vdpWrWdm", 32'(mem_wdm), 32'd1);
        checkOutput("vdpWrAddr", 32'(mem_addr), 32'h0000_0010);
        checkOutput("vdpRdataHeld", 32'(vdp_rdata), 32'h0000_A55A);

        // Aux read from the high lane, then a plain refresh in the same idle phase
        aux_req  = 1'b1;
        aux_we   = 1'b0;
        aux_addr = 17'h1_0002;
        mem_dout = 16'hBEEF;
        ack0 = ackCnt; ref0 = refCnt; rd0 = rdCnt;
        vdp_dlclk = 1'b0;
        vdp_dhclk = 1'b0;
        waitAck(20, seen);
        aux_req = 1'b0;
        checkOutput("auxRdAckSeen", 32'(seen), 32'd1);
        checkOutput("auxRdData", 32'(aux_rdata), 32'h0000_00BE);
        applyStimulus(1'b0, 1'b0, 10);
        applyStimulus(1'b1, 1'b0, 2);
        checkOutput("auxRdAckOnce", 32'(ackCnt - ack0), 32'd1);
        checkOutput("auxRdReadCount", 32'(rdCnt - rd0), 32'd1);
        checkOutput("idleRefreshOnce", 32'(refCnt - ref0), 32'd1);

        // Aux held through 20 idle phases: refresh forced in phases 9 and 18
        aux_req   = 1'b1;
        aux_we    = 1'b1;
        aux_addr  = 17'h0_0005;
        aux_wdata = 8'h77;
        for (int p = 0; p < 20; p++) begin
            ref0 = refCnt;
            ack0 = ackCnt;
            applyStimulus(1'b0, 1'b0, 8);
            applyStimulus(1'b1, 1'b0, 2);
            phaseRef[p] = refCnt - ref0;
            phaseAck[p] = ackCnt - ack0;
        end
        aux_req = 1'b0;
        earlyRef = 0; ackedPhases = 0; totalRef = 0;
        for (int p = 0; p < 20; p++) begin
            if (p < 8) earlyRef += phaseRef[p];
            totalRef += phaseRef[p];
            if (phaseAck[p] > 0) ackedPhases++;
        end
        checkOutput("starveNoEarlyRefresh", 32'(earlyRef), 32'd0);
        checkOutput("starveForcedPhase9", 32'(phaseRef[8]), 32'd1);
        checkOutput("starveTotalRefresh", 32'(totalRef), 32'd2);
        checkOutput("starveAuxEveryPhase", 32'(ackedPhases), 32'd20);
        checkOutput("auxWrDin", 32'(mem_din), 32'h0000_7777);
        checkOutput("auxWrWdm", 32'(mem_wdm), 32'd2);
`ifdef ARB_STATS_EN
        checkOutput("statForced", 32'(stat_forced_refresh), 32'd2);
`endif

        // Controller busy for the whole VDP slot
        mem_busy = 1'b1;
        vdp_we_n = 1'b1;
        rd0 = rdCnt; wr0 = wrCnt; ovr0 = ovrCnt;
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 3);
        mem_busy = 1'b0;
        checkOutput("ovrNoStrobe", 32'((rdCnt - rd0) + (wrCnt - wr0)), 32'd0);
        checkOutput("ovrPulseOnce", 32'(ovrCnt - ovr0), 32'd1);
`ifdef ARB_STATS_EN
        checkOutput("statOverruns", 32'(stat_overruns), 32'd1);
`endif

        // Async reset while an aux read is outstanding
        aux_req  = 1'b1;
        aux_we   = 1'b0;
        aux_addr = 17'h0_0003;
        mem_dout = 16'h1234;
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("rstAuxStrobe", 32'(mem_read), 32'd1);
        mem_busy = 1'b1;
        repeat (2) @(posedge clk_w);
        #2;
        ack0 = ackCnt;
        reset_n_w = 1'b0;
        #1;
        checkOutput("midRstMemAddr", 32'(mem_addr), 32'd0);
        checkOutput("midRstMemDin", 32'(mem_din), 32'd0);
        checkOutput("midRstVdpRdata", 32'(vdp_rdata), 32'd0);
        checkOutput("midRstAuxRdata", 32'(aux_rdata), 32'd0);
        repeat (2) @(posedge clk_w);
        #1;
        checkOutput("midRstNoAck", 32'(ackCnt - ack0), 32'd0);
        mem_busy  = 1'b0;
        reset_n_w = 1'b1;
        waitAck(20, seen);
        aux_req = 1'b0;
        checkOutput("reissueAckSeen", 32'(seen), 32'd1);
        checkOutput("reissueRdata", 32'(aux_rdata), 32'h0000_0034);
        applyStimulus(1'b1, 1'b0, 2);
        checkOutput("reissueAckOnce", 32'(ackCnt - ack0), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
